tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter TOKEN_RUN, default 4: consecutive aligned control tokens required to declare lock.
REQ-002 SHALL have parameter SEARCH_TIMEOUT, default 2048: cycles in SEARCH without lock before the alignment offset advances.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles in LOCKED without any control token before lock is dropped.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port tmds_in, input, 10 bits: raw deserialised word, one per clk; bit 0 is the earliest serial bit.
REQ-007 SHALL have port data, output, 8 bits: decoded pixel byte.
REQ-008 SHALL have port ctrl, output, 2 bits: decoded control value {C1,C0}.
REQ-009 SHALL have port de, output, 1 bit: 1 = data period, 0 = control period or idle.
REQ-010 SHALL have port locked, output, 1 bit: symbol alignment established.
REQ-011 SHALL have port offset, output, 4 bits: current bit-alignment offset, 0..9.

Function
REQ-012 SHALL register each tmds_in into prev, and form window = {tmds_in, prev} (20 bits, prev in the low half).
REQ-013 SHALL register aligned = window[offset+9 : offset] into aligned_q every cycle.
REQ-014 SHALL classify aligned_q as a control token only if it equals exactly one of the four tokens below; every other value is a data symbol.
- 10'b1101010100 -> ctrl 00
- 10'b0010101011 -> ctrl 01
- 10'b0101010100 -> ctrl 10
- 10'b1010101011 -> ctrl 11
REQ-015 SHALL decode a data symbol as follows:
- d = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0]
- q[0] = d[0]
- for i = 1..7: q[i] = aligned_q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
REQ-016 SHALL register outputs one cycle after aligned_q; total latency is 3 rising edges from tmds_in to data/ctrl/de.
REQ-017 SHALL, when locked=1 and aligned_q is a token, drive de=0, ctrl=token value and data=0.
REQ-018 SHALL, when locked=1 and aligned_q is a data symbol, drive de=1, data=q and hold ctrl at its last value.
REQ-019 SHALL, when locked=0, force data=0, ctrl=00 and de=0 regardless of input.
REQ-020 SHALL implement a two-state FSM: SEARCH and LOCKED.
REQ-021 In SEARCH, the FSM SHALL maintain run_cnt and search_timer as follows:
- token in aligned_q: run_cnt increments
- data symbol in aligned_q: run_cnt clears to 0
- search_timer increments every cycle
REQ-022 SHALL transition SEARCH->LOCKED on the cycle run_cnt reaches TOKEN_RUN; locked=1 is registered on that same edge, and outputs decode from the next aligned_q onward.
REQ-023 SHALL, when search_timer reaches SEARCH_TIMEOUT-1 without lock, do all of the following on the same edge:
- advance offset by 1, wrapping 9->0
- clear run_cnt
- clear search_timer
REQ-024 SHALL give lock priority over offset advance when both conditions occur on the same cycle; offset SHALL NOT change.
REQ-025 SHALL hold offset constant while in LOCKED.
REQ-026 In LOCKED, the FSM SHALL maintain gap_timer:
- clears on every aligned token
- otherwise increments
REQ-027 SHALL, when gap_timer reaches LOCK_TIMEOUT-1, return to SEARCH with locked=0, run_cnt=0 and search_timer=0, keeping the current offset.
REQ-028 SHALL size every counter to hold its parameter value without overflow and saturate nothing; the timeout comparisons bound each counter.
REQ-029 SHALL contain no combinational path from tmds_in to any output.

Reset
REQ-030 SHALL, when rst=1 at a rising edge, set all of the following on that edge, taking priority over all other activity including mid-lock:
- prev=0, aligned_q=0
- data=0, ctrl=00, de=0
- locked=0, offset=0
- run_cnt=0, search_timer=0, gap_timer=0
- FSM state = SEARCH
REQ-031 SHALL begin normal operation on the first edge with rst=0.

Verification
REQ-032 Reset: rst=1 for 2 cycles with random tmds_in -> data=0x00, ctrl=00, de=0, locked=0, offset=0.
REQ-033 Aligned lock and decode, offset 0:
- stimulus: 6x 10'b1101010100, then 0x100, 0x200, 10'b0010101011, 10'b0101010100, 10'b1010101011
- locked=1 after the 4th token reaches aligned_q
- then, 3 edges after each input: de=1/data=0x00, de=1/data=0xFF, de=0/ctrl=01, de=0/ctrl=10, de=0/ctrl=11
REQ-034 Bit-slip search:
- stimulus: continuous 10'b1101010100 token stream delayed by 3 serial bits, with TOKEN_RUN tokens per blanking burst
- locked=1 with offset=3 after at most 3xSEARCH_TIMEOUT + 8 cycles
- de=0 throughout
REQ-035 Lock loss:
- stimulus: after lock, LOCK_TIMEOUT consecutive 0x100 words
- locked falls exactly LOCK_TIMEOUT cycles after the last token left aligned_q
- de=0 and data=0 from the next cycle on
- offset unchanged
REQ-036 Reset mid-lock: rst=1 for one cycle while locked=1 with de=1 -> the next edge shows locked=0, de=0, offset=0; re-lock requires TOKEN_RUN fresh tokens.
REQ-037 Broken run: 3 tokens, 1 data word, 3 tokens -> locked stays 0; a 4th consecutive token then sets locked=1.

Source files
------------

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//   Recovers 10-bit TMDS symbol alignment from a raw deserialised word stream
//   and decodes each aligned symbol into either a control value or a pixel
//   byte. Alignment is found by sliding a 10-bit window across two adjacent
//   input words until a run of control tokens is seen. Once locked, the
//   offset is frozen until control tokens stop arriving for too long.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset
//   tmds_in in  10  raw word, bit 0 is the earliest serial bit
//   data    out  8  decoded pixel byte (0 outside data periods)
//   ctrl    out  2  decoded control value {C1,C0}
//   de      out  1  1 = data period
//   locked  out  1  symbol alignment established
//   offset  out  4  current bit-alignment offset, 0..9
//
// Latency: 3 rising edges from tmds_in to data/ctrl/de. All outputs are
// driven from registers.
// -----------------------------------------------------------------------------
module tmds_decoder #(
  parameter int TOKEN_RUN      = 4,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_in,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_ZERO  = RUN_W'(0);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
  localparam logic [SRCH_W-1:0] SRCH_ZERO = SRCH_W'(0);
  localparam logic [SRCH_W-1:0] SRCH_ONE  = SRCH_W'(1);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_ZERO  = GAP_W'(0);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Selects the 10-bit symbol starting at bit 'off' of the two-word window.
  // The top window bit (tmds_in[9]) is never reachable with off <= 9, so the
  // window is passed without it.
  function automatic logic [9:0] slice_window(input logic [18:0] win,
                                               input logic [3:0]  off);
    case (off)
      4'd0:    return win[9:0];
      4'd1:    return win[10:1];
      4'd2:    return win[11:2];
      4'd3:    return win[12:3];
      4'd4:    return win[13:4];
      4'd5:    return win[14:5];
      4'd6:    return win[15:6];
      4'd7:    return win[16:7];
      4'd8:    return win[17:8];
      4'd9:    return win[18:9];
      default: return win[9:0];
    endcase
  endfunction

  // Returns {hit, ctrl}; hit is set only for an exact control-token match.
  function automatic logic [2:0] token_lookup(input logic [9:0] sym);
    case (sym)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // TMDS data-symbol decode: undo the optional inversion (bit 9), then undo
  // the XOR/XNOR transition chain selected by bit 8.
  function automatic logic [7:0] tmds_data_decode(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  state_e            state_q, state_d;
  logic [9:0]        prev_q;
  logic [9:0]        aligned_q, aligned_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [SRCH_W-1:0] srch_q, srch_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              de_q, de_d;
  logic [2:0]        tok_s;
  logic              tok_hit_s;
  logic [1:0]        tok_ctrl_s;

  assign aligned_d  = slice_window({tmds_in[8:0], prev_q}, offset_q);
  assign tok_s      = token_lookup(aligned_q);
  assign tok_hit_s  = tok_s[2];
  assign tok_ctrl_s = tok_s[1:0];

  // Alignment search / lock tracking next-state logic.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    srch_d   = srch_q;
    gap_d    = gap_q;
    case (state_q)
      ST_SEARCH: begin
        srch_d = srch_q + SRCH_ONE;
        if (tok_hit_s) begin
          run_d = run_q + RUN_ONE;
        end else begin
          run_d = RUN_ZERO;
        end
        // Lock wins over an offset advance landing on the same cycle.
        if (tok_hit_s && (run_q == RUN_LAST)) begin
          state_d = ST_LOCKED;
          run_d   = RUN_ZERO;
          srch_d  = SRCH_ZERO;
          gap_d   = GAP_ZERO;
        end else if (srch_q == SRCH_LAST) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : (offset_q + 4'd1);
          run_d    = RUN_ZERO;
          srch_d   = SRCH_ZERO;
        end else begin
          gap_d = GAP_ZERO;
        end
      end
      ST_LOCKED: begin
        // Too long without a token: drop back to searching at this offset.
        if (gap_q == GAP_LAST) begin
          state_d = ST_SEARCH;
          run_d   = RUN_ZERO;
          srch_d  = SRCH_ZERO;
          gap_d   = GAP_ZERO;
        end else if (tok_hit_s) begin
          gap_d = GAP_ZERO;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        offset_d = 4'd0;
        run_d    = RUN_ZERO;
        srch_d   = SRCH_ZERO;
        gap_d    = GAP_ZERO;
      end
    endcase
  end

  // Output decode of the aligned symbol; everything is forced to zero
  // while alignment is not established.
  always_comb begin
    data_d = 8'h00;
    ctrl_d = 2'b00;
    de_d   = 1'b0;
    if (state_q == ST_LOCKED) begin
      if (tok_hit_s) begin
        ctrl_d = tok_ctrl_s;
      end else begin
        de_d   = 1'b1;
        data_d = tmds_data_decode(aligned_q);
        ctrl_d = ctrl_q;
      end
    end else begin
      ctrl_d = 2'b00;
    end
  end

  // Pipeline, FSM and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SEARCH;
      prev_q    <= 10'd0;
      aligned_q <= 10'd0;
      offset_q  <= 4'd0;
      run_q     <= RUN_ZERO;
      srch_q    <= SRCH_ZERO;
      gap_q     <= GAP_ZERO;
      data_q    <= 8'h00;
      ctrl_q    <= 2'b00;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= tmds_in;
      aligned_q <= aligned_d;
      offset_q  <= offset_d;
      run_q     <= run_d;
      srch_q    <= srch_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = (state_q == ST_LOCKED);
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
//   Self-checking bench for tmds_decoder. A behavioural model of the decoder
//   is advanced once per clock edge from the same stimulus; a compare process
//   checks every output on every falling edge. Directed sequences add literal
//   expectations for reset, aligned lock/decode, bit-slip search, lock loss,
//   reset while locked and a broken token run; a randomized serial stream
//   with random bit delay follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tmds_decoder;

  localparam int TR = 4;
  localparam int ST = 64;
  localparam int LT = 128;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_in = 10'd0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  tmds_decoder #(
    .TOKEN_RUN(TR),
    .SEARCH_TIMEOUT(ST),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tmds_in(tmds_in),
    .data(data),
    .ctrl(ctrl),
    .de(de),
    .locked(locked),
    .offset(offset)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [9:0] tok_tbl [4];
  logic [9:0] m_prev;
  logic [9:0] m_sym;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  logic       m_de;
  logic       m_locked;
  int         m_off;
  int         m_run;
  int         m_timer;
  int         m_gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int tok_index(input logic [9:0] s);
    for (int i = 0; i < 4; i++) begin
      if (tok_tbl[i] == s) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] mdec(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] q;
    d = s[7:0] ^ {8{s[9]}};
    q = d ^ {d[6:0], 1'b0};
    if (!s[8]) q = q ^ 8'hFE;
    return q;
  endfunction

  // Advance the model by one rising edge with inputs (w, r).
  task automatic model_edge(input logic [9:0] w, input logic r);
    int         ti;
    logic [19:0] sh;
    logic [9:0] nsym;
    if (r) begin
      m_prev = 10'd0; m_sym = 10'd0;
      m_data = 8'h00; m_ctrl = 2'b00; m_de = 1'b0;
      m_locked = 1'b0; m_off = 0;
      m_run = 0; m_timer = 0; m_gap = 0;
    end else begin
      sh   = {w, m_prev} >> m_off;
      nsym = sh[9:0];
      ti   = tok_index(m_sym);
      if (!m_locked) begin
        m_data = 8'h00; m_ctrl = 2'b00; m_de = 1'b0;
      end else if (ti >= 0) begin
        m_data = 8'h00; m_ctrl = 2'(ti); m_de = 1'b0;
      end else begin
        m_data = mdec(m_sym); m_de = 1'b1;
      end
      if (!m_locked) begin
        m_run = (ti >= 0) ? m_run + 1 : 0;
        m_timer++;
        if (m_run == TR) begin
          m_locked = 1'b1; m_run = 0; m_timer = 0; m_gap = 0;
        end else if (m_timer == ST) begin
          m_off = (m_off + 1) % 10; m_run = 0; m_timer = 0;
        end
      end else begin
        if (m_gap == LT - 1) begin
          m_locked = 1'b0; m_run = 0; m_timer = 0; m_gap = 0;
        end else begin
          m_gap = (ti >= 0) ? 0 : m_gap + 1;
        end
      end
      m_sym  = nsym;
      m_prev = w;
    end
  endtask

  task automatic step(input logic [9:0] w, input logic r);
    @(negedge clk);
    tmds_in = w;
    rst     = r;
    @(posedge clk);
    model_edge(w, r);
    #1;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data",   32'(data),   32'(m_data));
      chk("m_ctrl",   32'(ctrl),   32'(m_ctrl));
      chk("m_de",     32'(de),     32'(m_de));
      chk("m_locked", 32'(locked), 32'(m_locked));
      chk("m_offset", 32'(offset), 32'(m_off));
    end
  end

  // Random serial stream: token bursts and random data runs, shifted by
  // 'dly' serial bits, chopped into 10-bit words.
  task automatic run_random(input int ncyc, input int dly);
    logic       sq[$];
    int         left;
    bit         burst;
    logic [9:0] sym;
    logic [9:0] w;
    logic       r;
    left  = 0;
    burst = 1'b0;
    for (int i = 0; i < dly; i++) sq.push_back(1'($urandom_range(0, 1)));
    for (int c = 0; c < ncyc; c++) begin
      while (sq.size() < 10) begin
        if (left == 0) begin
          burst = !burst;
          if (burst) left = int'($urandom_range(3, 7));
          else if ($urandom_range(0, 7) == 0) left = 140;
          else left = int'($urandom_range(1, 30));
        end
        sym = burst ? tok_tbl[$urandom_range(0, 3)] : 10'($urandom_range(0, 1023));
        for (int b = 0; b < 10; b++) sq.push_back(sym[b]);
        left--;
      end
      for (int b = 0; b < 10; b++) w[b] = sq.pop_front();
      r = ($urandom_range(0, 599) == 0);
      step(w, r);
    end
  endtask

  initial begin
    logic [9:0] t;
    logic [9:0] px;
    logic [9:0] x;
    int         n;
    bit         saw_de;

    tok_tbl = '{T00, T01, T10, T11};
    m_prev = 10'd0; m_sym = 10'd0; m_data = 8'h00; m_ctrl = 2'b00;
    m_de = 1'b0; m_locked = 1'b0; m_off = 0; m_run = 0; m_timer = 0; m_gap = 0;

    // reset with random input
    step(10'($urandom), 1'b1);
    chk_en = 1'b1;
    step(10'($urandom), 1'b1);
    chk("rst_data",   32'(data),   32'h00);
    chk("rst_ctrl",   32'(ctrl),   32'd0);
    chk("rst_de",     32'(de),     32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);

    // aligned lock at offset 0 and decode
    for (int i = 1; i <= 5; i++) step(T00, 1'b0);
    chk("lock_not_yet", 32'(locked), 32'd0);
    step(T00, 1'b0);
    chk("lock_4th_tok", 32'(locked), 32'd1);
    step(10'h100, 1'b0);
    step(10'h200, 1'b0);
    chk("tok_de",   32'(de),   32'd0);
    chk("tok_ctrl", 32'(ctrl), 32'd0);
    step(T01, 1'b0);
    chk("d100_de",   32'(de),   32'd1);
    chk("d100_data", 32'(data), 32'h00);
    step(T10, 1'b0);
    chk("d200_de",   32'(de),   32'd1);
    chk("d200_data", 32'(data), 32'hFF);
    step(T11, 1'b0);
    chk("c01_de",   32'(de),   32'd0);
    chk("c01_ctrl", 32'(ctrl), 32'd1);
    chk("c01_data", 32'(data), 32'h00);
    step(10'h100, 1'b0);
    chk("c10_ctrl", 32'(ctrl), 32'd2);
    step(10'h100, 1'b0);
    chk("c11_ctrl", 32'(ctrl), 32'd3);
    chk("c11_de",   32'(de),   32'd0);

    // lock loss: last token (step 11) leaves aligned_q at edge 13
    for (int s = 14; s <= 14 + LT; s++) begin
      step(10'h100, 1'b0);
      if (s == 14) begin
        chk("hold_ctrl", 32'(ctrl), 32'd3);
        chk("hold_de",   32'(de),   32'd1);
      end
      if (s == 12 + LT) chk("loss_still_locked", 32'(locked), 32'd1);
      if (s == 13 + LT) begin
        chk("loss_unlocked", 32'(locked), 32'd0);
        chk("loss_offset",   32'(offset), 32'd0);
      end
      if (s == 14 + LT) begin
        chk("loss_de",   32'(de),   32'd0);
        chk("loss_data", 32'(data), 32'h00);
      end
    end

    // bit-slip search: token stream delayed by 3 serial bits
    step(10'd0, 1'b1);
    step(10'd0, 1'b1);
    t = T00;
    px = T00;
    n = 0;
    saw_de = 1'b0;
    while (!locked && n < 3 * ST + 8) begin
      step({t[6:0], px[9:7]}, 1'b0);
      px = t;
      n++;
      if (de) saw_de = 1'b1;
    end
    chk("slip_locked", 32'(locked), 32'd1);
    chk("slip_offset", 32'(offset), 32'd3);
    chk("slip_no_de",  32'(saw_de), 32'd0);
    x = 10'h200;
    for (int i = 0; i < 6; i++) begin
      step({x[6:0], px[9:7]}, 1'b0);
      px = x;
    end
    chk("slip_data_de",  32'(de),     32'd1);
    chk("slip_data",     32'(data),   32'hFF);
    chk("slip_offset_h", 32'(offset), 32'd3);

    // reset while locked with de=1
    step(10'd0, 1'b1);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_de",     32'(de),     32'd0);
    chk("midrst_offset", 32'(offset), 32'd0);
    for (int i = 0; i < 5; i++) step(T00, 1'b0);
    chk("relock_not_yet", 32'(locked), 32'd0);
    step(T00, 1'b0);
    chk("relock", 32'(locked), 32'd1);

    // broken run: T T T D T T T T D D
    step(10'd0, 1'b1);
    step(T00, 1'b0); step(T00, 1'b0); step(T00, 1'b0);
    step(10'h100, 1'b0);
    step(T00, 1'b0); step(T00, 1'b0); step(T00, 1'b0); step(T00, 1'b0);
    step(10'h100, 1'b0);
    chk("broken_run", 32'(locked), 32'd0);
    step(10'h100, 1'b0);
    chk("fourth_tok", 32'(locked), 32'd1);

    // randomized serial streams with random bit delay
    for (int seg = 0; seg < 4; seg++) begin
      step(10'd0, 1'b1);
      run_random(2000, int'($urandom_range(0, 9)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
